seven_seg_scan_ctrl: RTL

//  Parametrised multiplexed 7-segment scan controller, successor to the 6-digit fixed-rate controller.

---
 rtl/seven_seg_scan_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit time slots with dead time, PWM brightness,
// leading-zero blanking and frame-synchronous input snapshots. All pin outputs are registered.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_DIGITS-1:0]   DisplayEnables,
    input  logic [4*NUM_DIGITS-1:0] Data,
    input  logic [NUM_DIGITS-1:0]   Points,
    input  logic [3:0]              Brightness,
    input  logic                    LeadingZeroBlank,
    output logic [7:0]              SevenSegsAndPoint,
    output logic [NUM_DIGITS-1:0]   ShowOneofN,
    output logic                    FrameStart
);

    localparam int unsigned CW      = $clog2(SCAN_DIV);
    localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for (Brightness+1)*(SCAN_DIV-BLANK_CYCLES) <= 16*2^CW
    localparam int unsigned PW      = CW + 5;
    localparam int unsigned LIT_LEN = SCAN_DIV - BLANK_CYCLES;

    localparam logic [7:0]            SEG_INV = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    frame_q, frame_d;
    logic                    load_q;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;

    logic [4*NUM_DIGITS-1:0] data_q;
    logic [NUM_DIGITS-1:0]   en_q, pt_q;
    logic [3:0]              bri_q;
    logic                    lzb_q;

    logic                    cnt_wrap, shadow_load, lit, on, drive, zrun;
    logic [PW-1:0]           lit_ofs, duty_lim;
    logic [NUM_DIGITS-1:0]   zblank;
    logic [3:0]              cur_nib;
    logic                    cur_en, cur_pt, cur_zb;
    logic [6:0]              glyph;

    // Slot/digit sequencing, duty window, blanking and pin pattern for the current cycle
    always_comb begin
        cnt_wrap    = 1'b0;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        frame_d     = 1'b0;
        shadow_load = frame_q | load_q;
        zrun        = 1'b1;
        zblank      = '0;
        cur_nib     = 4'h0;
        cur_en      = 1'b0;
        cur_pt      = 1'b0;
        cur_zb      = 1'b0;
        glyph       = 7'h00;
        seg_d       = SEG_INV;
        dig_d       = DIG_INV;

        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_wrap = 1'b1;
            cnt_d    = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                idx_d   = '0;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        lit      = (cnt_q >= CW'(BLANK_CYCLES));
        lit_ofs  = PW'(cnt_q) - PW'(BLANK_CYCLES);
        duty_lim = (PW'(bri_q) + PW'(1)) * PW'(LIT_LEN);
        on       = (lit_ofs << 4) < duty_lim;

        // A digit is zero-blanked when it and every more-significant digit are zero
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zrun      = zrun && (data_q[4*i +: 4] == 4'h0);
            zblank[i] = lzb_q && zrun && (i != 0);
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = data_q[4*i +: 4];
                cur_en  = en_q[i];
                cur_pt  = pt_q[i];
                cur_zb  = zblank[i];
            end
        end

        case (cur_nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase

        drive = lit && on && cur_en && !(cur_zb && !cur_pt);
        if (drive) begin
            seg_d = {cur_pt, cur_zb ? 7'h00 : glyph} ^ SEG_INV;
            dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_INV;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
            load_q  <= 1'b1;
            seg_q   <= SEG_INV;
            dig_q   <= DIG_INV;
            data_q  <= '0;
            en_q    <= '0;
            pt_q    <= '0;
            bri_q   <= 4'h0;
            lzb_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            load_q  <= 1'b0;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            if (shadow_load) begin
                data_q <= Data;
                en_q   <= DisplayEnables;
                pt_q   <= Points;
                bri_q  <= Brightness;
                lzb_q  <= LeadingZeroBlank;
            end
        end
    end

    assign SevenSegsAndPoint = seg_q;
    assign ShowOneofN        = dig_q;
    assign FrameStart        = frame_q;

endmodule
